// File: rtl/accel_cmd_pkg.sv
// accel_cmd_pkg: shared constants and types for the accelerator command front end.
//   ACCEL_OPCODE  custom opcode that carries accelerator commands
//   RD_*          rd field-select codes (shadow field writes, channel select,
//                 interrupt clear, triggers)
//   *_W           widths of the per-channel configuration fields
//   ch_state_e    per-channel launch state
package accel_cmd_pkg;

  localparam logic [6:0] ACCEL_OPCODE = 7'b0001011;

  localparam logic [4:0] RD_DIM         = 5'd0;
  localparam logic [4:0] RD_DEPTH       = 5'd1;
  localparam logic [4:0] RD_IMG_OFF     = 5'd2;
  localparam logic [4:0] RD_FLT_OFF     = 5'd3;
  localparam logic [4:0] RD_OUT_OFF     = 5'd4;
  localparam logic [4:0] RD_HALFSIZE    = 5'd5;
  localparam logic [4:0] RD_STRIDE      = 5'd6;
  localparam logic [4:0] RD_LENGTH      = 5'd7;
  localparam logic [4:0] RD_BIAS        = 5'd8;
  localparam logic [4:0] RD_CH_SELECT   = 5'd9;
  localparam logic [4:0] RD_IRQ_CLEAR   = 5'd29;
  localparam logic [4:0] RD_TRIGGER_ALL = 5'd30;
  localparam logic [4:0] RD_TRIGGER     = 5'd31;

  localparam int IMM_W    = 20;
  localparam int DIM_W    = 8;
  localparam int DEPTH_W  = 9;
  localparam int HALF_W   = 2;
  localparam int STRIDE_W = 3;
  localparam int LEN_W    = 13;
  localparam int BIAS_W   = 18;

  typedef enum logic [1:0] {
    CH_IDLE  = 2'd0,
    CH_START = 2'd1,
    CH_RUN   = 2'd2
  } ch_state_e;

  // Saturating increment for the optional run-cycle counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/accel_cmd_channel.sv
// accel_cmd_channel: one accelerator channel of the command front end.
// Holds the shadow configuration (written by decoded commands at any time),
// the active configuration presented to the datapath (copied from shadow when
// a trigger is accepted), the launch FSM and the sticky interrupt bit.
// Optional macro ACCEL_CMD_PERF_EN adds a saturating run-cycle counter.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wr_en/wr_sel/wr_data  shadow field write (field chosen by rd code)
//   trig            accepted trigger for this channel (only issued while IDLE)
//   irq_clr         clear the sticky interrupt bit
//   done_in         completion pulse from the datapath
//   cfg_*           active configuration
//   start, busy     launch pulse / START-or-RUN
//   intr            sticky interrupt bit
//   state           FSM state, exported for the top and for debug
//   cycles          (ACCEL_CMD_PERF_EN only) RUN cycles of the last launch
module accel_cmd_channel
  import accel_cmd_pkg::*;
#(
  parameter int ADDR_W = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [4:0]          wr_sel,
  input  logic [IMM_W-1:0]    wr_data,
  input  logic                trig,
  input  logic                irq_clr,
  input  logic                done_in,
  output logic [DIM_W-1:0]    cfg_image_dim,
  output logic [DEPTH_W-1:0]  cfg_image_depth,
  output logic [ADDR_W-1:0]   cfg_image_off,
  output logic [ADDR_W-1:0]   cfg_filter_off,
  output logic [ADDR_W-1:0]   cfg_output_off,
  output logic [HALF_W-1:0]   cfg_halfsize,
  output logic [STRIDE_W-1:0] cfg_stride,
  output logic [LEN_W-1:0]    cfg_filter_len,
  output logic [BIAS_W-1:0]   cfg_filter_bias,
  output logic                start,
  output logic                busy,
  output logic                intr,
  output ch_state_e           state
`ifdef ACCEL_CMD_PERF_EN
  ,
  output logic [31:0]         cycles
`endif
);

  typedef struct packed {
    logic [DIM_W-1:0]    dim;
    logic [DEPTH_W-1:0]  depth;
    logic [ADDR_W-1:0]   img_off;
    logic [ADDR_W-1:0]   flt_off;
    logic [ADDR_W-1:0]   out_off;
    logic [HALF_W-1:0]   halfsize;
    logic [STRIDE_W-1:0] stride;
    logic [LEN_W-1:0]    length;
    logic [BIAS_W-1:0]   bias;
  } cfg_t;

  cfg_t      shadow_q, shadow_d;
  cfg_t      active_q, active_d;
  ch_state_e state_q, state_d;
  logic      intr_q, intr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
      state_q  <= CH_IDLE;
      intr_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      state_q  <= state_d;
      intr_q   <= intr_d;
    end
  end

  // Shadow writes are allowed while running; only a trigger moves them to active.
  always_comb begin
    shadow_d = shadow_q;
    if (wr_en) begin
      case (wr_sel)
        RD_DIM:      shadow_d.dim      = wr_data[DIM_W-1:0];
        RD_DEPTH:    shadow_d.depth    = wr_data[DEPTH_W-1:0];
        RD_IMG_OFF:  shadow_d.img_off  = wr_data[ADDR_W-1:0];
        RD_FLT_OFF:  shadow_d.flt_off  = wr_data[ADDR_W-1:0];
        RD_OUT_OFF:  shadow_d.out_off  = wr_data[ADDR_W-1:0];
        RD_HALFSIZE: shadow_d.halfsize = wr_data[HALF_W-1:0];
        RD_STRIDE:   shadow_d.stride   = wr_data[STRIDE_W-1:0];
        RD_LENGTH:   shadow_d.length   = wr_data[LEN_W-1:0];
        RD_BIAS:     shadow_d.bias     = wr_data[BIAS_W-1:0];
        default:     ;
      endcase
    end
    active_d = trig ? shadow_q : active_q;
  end

  // Launch FSM. Clear is applied before set so a same-cycle completion wins.
  always_comb begin
    state_d = state_q;
    intr_d  = intr_q;
    if (irq_clr) intr_d = 1'b0;
    case (state_q)
      CH_IDLE:  if (trig) state_d = CH_START;
      CH_START: state_d = CH_RUN;
      CH_RUN: begin
        if (done_in) begin
          state_d = CH_IDLE;
          intr_d  = 1'b1;
        end
      end
      default:  state_d = CH_IDLE;
    endcase
  end

  assign start           = (state_q == CH_START);
  assign busy            = (state_q == CH_START) || (state_q == CH_RUN);
  assign intr            = intr_q;
  assign state           = state_q;
  assign cfg_image_dim   = active_q.dim;
  assign cfg_image_depth = active_q.depth;
  assign cfg_image_off   = active_q.img_off;
  assign cfg_filter_off  = active_q.flt_off;
  assign cfg_output_off  = active_q.out_off;
  assign cfg_halfsize    = active_q.halfsize;
  assign cfg_stride      = active_q.stride;
  assign cfg_filter_len  = active_q.length;
  assign cfg_filter_bias = active_q.bias;

`ifdef ACCEL_CMD_PERF_EN
  logic [31:0] cycles_q, cycles_d;

  // Cleared during START, counts every RUN cycle (including the done cycle),
  // then holds until the next launch.
  always_comb begin
    cycles_d = cycles_q;
    if (state_q == CH_START)    cycles_d = '0;
    else if (state_q == CH_RUN) cycles_d = sat_inc(cycles_q);
  end

  always_ff @(posedge clk) begin
    if (rst) cycles_q <= '0;
    else     cycles_q <= cycles_d;
  end

  assign cycles = cycles_q;
`endif

endmodule

// File: rtl/accel_cmd_ctrl.sv
// accel_cmd_ctrl: multi-channel command front end for the conv accelerator.
// Decodes custom-opcode instructions into per-channel shadow configuration,
// launches NUM_CH independent cores, tracks busy/done and raises sticky
// interrupts. Optional macro ACCEL_CMD_PERF_EN adds the ch_cycles port.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   instr_valid/instruction/instr_ready  instruction handshake
//   cfg_*                 active configuration, channel c in slice c
//   ch_start/ch_done/ch_busy  per-channel launch pulse, completion, busy
//   accel_interrupt, irq  sticky per-channel done flags and their registered OR
//   ch_cycles             (ACCEL_CMD_PERF_EN only) per-channel RUN cycle count
//
// Handshake: an instruction transfers on any cycle with instr_valid and
// instr_ready both high. instr_ready is low only during reset or when the
// presented instruction is a trigger whose target channel(s) are not IDLE; it
// depends on the instruction and channel state, not on instr_valid. The source
// holds a stalled trigger until accepted; nothing is dropped.
module accel_cmd_ctrl
  import accel_cmd_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       instr_valid,
  input  logic [31:0]                instruction,
  output logic                       instr_ready,
  output logic [NUM_CH*DIM_W-1:0]    cfg_image_dim,
  output logic [NUM_CH*DEPTH_W-1:0]  cfg_image_depth,
  output logic [NUM_CH*ADDR_W-1:0]   cfg_image_off,
  output logic [NUM_CH*ADDR_W-1:0]   cfg_filter_off,
  output logic [NUM_CH*ADDR_W-1:0]   cfg_output_off,
  output logic [NUM_CH*HALF_W-1:0]   cfg_halfsize,
  output logic [NUM_CH*STRIDE_W-1:0] cfg_stride,
  output logic [NUM_CH*LEN_W-1:0]    cfg_filter_len,
  output logic [NUM_CH*BIAS_W-1:0]   cfg_filter_bias,
  output logic [NUM_CH-1:0]          ch_start,
  input  logic [NUM_CH-1:0]          ch_done,
  output logic [NUM_CH-1:0]          ch_busy,
  output logic [NUM_CH-1:0]          accel_interrupt,
  output logic                       irq
`ifdef ACCEL_CMD_PERF_EN
  ,
  output logic [NUM_CH*32-1:0]       ch_cycles
`endif
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [6:0]       opcode;
  logic [4:0]       rd;
  logic [IMM_W-1:0] imm;
  logic [CH_W-1:0]  ptr_q, ptr_d;
  logic             irq_q, irq_d;
  logic             is_accel, stall, fire;
  logic [NUM_CH-1:0] ch_idle, wr_en, trig, irq_clr;
  ch_state_e        ch_state [NUM_CH];

  assign opcode   = instruction[6:0];
  assign rd       = instruction[11:7];
  assign imm      = instruction[31:12];
  assign is_accel = (opcode == ACCEL_OPCODE);

  always_comb begin
    stall = 1'b0;
    if (is_accel && rd == RD_TRIGGER)          stall = !ch_idle[ptr_q];
    else if (is_accel && rd == RD_TRIGGER_ALL) stall = !(&ch_idle);
  end

  assign instr_ready = !rst && !stall;
  assign fire        = instr_valid && instr_ready && is_accel;

  always_comb begin
    ptr_d = ptr_q;
    if (fire && rd == RD_CH_SELECT && imm < IMM_W'(NUM_CH)) ptr_d = imm[CH_W-1:0];
    irq_d = |accel_interrupt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      irq_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign wr_en[c]   = fire && (rd <= RD_BIAS) && (ptr_q == CH_W'(c));
    // fire already implies the targeted channel(s) are IDLE.
    assign trig[c]    = fire && ((rd == RD_TRIGGER_ALL) ||
                                 (rd == RD_TRIGGER && ptr_q == CH_W'(c)));
    assign irq_clr[c] = fire && (rd == RD_IRQ_CLEAR) && imm[c];
    assign ch_idle[c] = (ch_state[c] == CH_IDLE);

    accel_cmd_channel #(.ADDR_W(ADDR_W)) u_ch (
      .clk             (clk),
      .rst             (rst),
      .wr_en           (wr_en[c]),
      .wr_sel          (rd),
      .wr_data         (imm),
      .trig            (trig[c]),
      .irq_clr         (irq_clr[c]),
      .done_in         (ch_done[c]),
      .cfg_image_dim   (cfg_image_dim[c*DIM_W +: DIM_W]),
      .cfg_image_depth (cfg_image_depth[c*DEPTH_W +: DEPTH_W]),
      .cfg_image_off   (cfg_image_off[c*ADDR_W +: ADDR_W]),
      .cfg_filter_off  (cfg_filter_off[c*ADDR_W +: ADDR_W]),
      .cfg_output_off  (cfg_output_off[c*ADDR_W +: ADDR_W]),
      .cfg_halfsize    (cfg_halfsize[c*HALF_W +: HALF_W]),
      .cfg_stride      (cfg_stride[c*STRIDE_W +: STRIDE_W]),
      .cfg_filter_len  (cfg_filter_len[c*LEN_W +: LEN_W]),
      .cfg_filter_bias (cfg_filter_bias[c*BIAS_W +: BIAS_W]),
      .start           (ch_start[c]),
      .busy            (ch_busy[c]),
      .intr            (accel_interrupt[c]),
      .state           (ch_state[c])
`ifdef ACCEL_CMD_PERF_EN
      ,
      .cycles          (ch_cycles[c*32 +: 32])
`endif
    );
  end

endmodule

// File: tb/tb_accel_cmd_ctrl.sv
// tb_accel_cmd_ctrl: self-checking bench for accel_cmd_ctrl (NUM_CH=4, ADDR_W=20).
// A behavioural model (per-channel arrays of shadow/active fields, busy and
// interrupt bit vectors) predicts every output each cycle; directed scenarios
// are followed by a randomized instruction/done/reset stream.
module tb_accel_cmd_ctrl;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 20;
  localparam logic [6:0] OPC = 7'b0001011;
  localparam logic [4:0] R_DIM = 5'd0, R_LEN = 5'd7, R_SEL = 5'd9;
  localparam logic [4:0] R_CLR = 5'd29, R_TALL = 5'd30, R_TRIG = 5'd31;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic instr_valid = 1'b0;
  logic [31:0] instruction = '0;
  logic instr_ready;
  logic [NUM_CH*8-1:0]      cfg_image_dim;
  logic [NUM_CH*9-1:0]      cfg_image_depth;
  logic [NUM_CH*ADDR_W-1:0] cfg_image_off, cfg_filter_off, cfg_output_off;
  logic [NUM_CH*2-1:0]      cfg_halfsize;
  logic [NUM_CH*3-1:0]      cfg_stride;
  logic [NUM_CH*13-1:0]     cfg_filter_len;
  logic [NUM_CH*18-1:0]     cfg_filter_bias;
  logic [NUM_CH-1:0]        ch_start, ch_busy, accel_interrupt;
  logic [NUM_CH-1:0]        ch_done = '0;
  logic                     irq;
`ifdef ACCEL_CMD_PERF_EN
  logic [NUM_CH*32-1:0]     ch_cycles;
`endif

  always #5 clk = ~clk;

  accel_cmd_ctrl #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instruction(instruction),
    .instr_ready(instr_ready), .cfg_image_dim(cfg_image_dim),
    .cfg_image_depth(cfg_image_depth), .cfg_image_off(cfg_image_off),
    .cfg_filter_off(cfg_filter_off), .cfg_output_off(cfg_output_off),
    .cfg_halfsize(cfg_halfsize), .cfg_stride(cfg_stride),
    .cfg_filter_len(cfg_filter_len), .cfg_filter_bias(cfg_filter_bias),
    .ch_start(ch_start), .ch_done(ch_done), .ch_busy(ch_busy),
    .accel_interrupt(accel_interrupt), .irq(irq)
`ifdef ACCEL_CMD_PERF_EN
    , .ch_cycles(ch_cycles)
`endif
  );

  // ---------------- scoreboard counters / check ----------------
  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int fw [9];
  logic [19:0] m_shadow [NUM_CH][9];
  logic [19:0] m_active [NUM_CH][9];
  logic [NUM_CH-1:0] m_start, m_run, m_int;
  logic m_irq;
  int m_ptr;
  logic [31:0] m_cyc [NUM_CH];

  function automatic logic [19:0] fmask(input logic [19:0] v, input int w);
    logic [20:0] m;
    m = (21'h1 << w) - 21'h1;
    return v & m[19:0];
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, OPC};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      for (int f = 0; f < 9; f++) begin
        m_shadow[c][f] = '0;
        m_active[c][f] = '0;
      end
      m_cyc[c] = '0;
    end
    m_start = '0; m_run = '0; m_int = '0; m_irq = 1'b0; m_ptr = 0;
  endtask

  function automatic logic [127:0] obs_cfg(input int f);
    case (f)
      0: return 128'(cfg_image_dim);
      1: return 128'(cfg_image_depth);
      2: return 128'(cfg_image_off);
      3: return 128'(cfg_filter_off);
      4: return 128'(cfg_output_off);
      5: return 128'(cfg_halfsize);
      6: return 128'(cfg_stride);
      7: return 128'(cfg_filter_len);
      default: return 128'(cfg_filter_bias);
    endcase
  endfunction

  // ---------------- driver: one clock cycle ----------------
  // Entered at a negedge: drives inputs, checks all outputs against the
  // model, advances the model across the coming posedge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [NUM_CH-1:0] done,
                      output logic acc, output logic rdy);
    logic [6:0] opc;
    logic [4:0] rd;
    logic [19:0] imm;
    logic exp_ready;
    logic [NUM_CH-1:0] n_start, n_run, n_int;
    logic [127:0] exp;
    instr_valid = v; instruction = ins; ch_done = done;
    #1;
    opc = ins[6:0]; rd = ins[11:7]; imm = ins[31:12];
    exp_ready = 1'b1;
    if (rst) exp_ready = 1'b0;
    else if (opc == OPC && rd == R_TRIG && (m_start[m_ptr] || m_run[m_ptr])) exp_ready = 1'b0;
    else if (opc == OPC && rd == R_TALL && |(m_start | m_run)) exp_ready = 1'b0;
    rdy = instr_ready;
    check("instr_ready", instr_ready, exp_ready);
    check("ch_start", ch_start, m_start);
    check("ch_busy", ch_busy, m_start | m_run);
    check("accel_interrupt", accel_interrupt, m_int);
    check("irq", irq, m_irq);
    for (int f = 0; f < 9; f++) begin
      exp = '0;
      for (int c = 0; c < NUM_CH; c++) exp = exp | (128'(m_active[c][f]) << (c * fw[f]));
      check($sformatf("cfg_field%0d", f), obs_cfg(f), exp);
    end
`ifdef ACCEL_CMD_PERF_EN
    exp = '0;
    for (int c = 0; c < NUM_CH; c++) exp = exp | (128'(m_cyc[c]) << (c * 32));
    check("ch_cycles", 128'(ch_cycles), exp);
`endif
    acc = v && exp_ready;
    if (rst) begin
      model_reset();
    end else begin
      n_start = '0; n_run = m_run | m_start; n_int = m_int;
      for (int c = 0; c < NUM_CH; c++) if (m_run[c] && done[c]) n_run[c] = 1'b0;
      if (acc && opc == OPC) begin
        if (rd <= 5'd8) m_shadow[m_ptr][rd] = fmask(imm, fw[rd]);
        else if (rd == R_SEL) begin
          if (imm < NUM_CH) m_ptr = int'(imm);
        end else if (rd == R_CLR) n_int = n_int & ~imm[NUM_CH-1:0];
        else if (rd == R_TALL) begin
          for (int c = 0; c < NUM_CH; c++) begin
            n_start[c] = 1'b1;
            for (int f = 0; f < 9; f++) m_active[c][f] = m_shadow[c][f];
          end
        end else if (rd == R_TRIG) begin
          n_start[m_ptr] = 1'b1;
          for (int f = 0; f < 9; f++) m_active[m_ptr][f] = m_shadow[m_ptr][f];
        end
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (m_run[c] && done[c]) n_int[c] = 1'b1;
        if (m_start[c]) m_cyc[c] = '0;
        else if (m_run[c] && m_cyc[c] != 32'hFFFF_FFFF) m_cyc[c] = m_cyc[c] + 32'd1;
      end
      m_irq = |m_int;
      m_start = n_start; m_run = n_run; m_int = n_int;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic a, r;
    for (int k = 0; k < n; k++) step(1'b0, 32'h0, '0, a, r);
  endtask

  task automatic pulse(input logic [NUM_CH-1:0] m);
    logic a, r;
    step(1'b0, 32'h0, m, a, r);
  endtask

  task automatic issue(input logic [31:0] ins);
    logic a, r;
    a = 1'b0;
    for (int k = 0; k < 40 && !a; k++) step(1'b1, ins, '0, a, r);
    check("issue_accept_timeout", a, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic a, r;
    logic [4:0] rd;
    logic [19:0] imm;
    logic [6:0] opc;
    logic [NUM_CH-1:0] dn;
    int k;
    fw = '{8, 9, ADDR_W, ADDR_W, ADDR_W, 2, 3, 13, 18};
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle(2);                               // reset state checked with rst high
    rst = 1'b0;
    idle(1);

    // 1: select, write, trigger, complete, interrupt
    issue(mk(R_SEL, 20'd2));
    issue(mk(R_DIM, 20'd32));
    issue(mk(R_TRIG, 20'd0));
    check("t1_dim_ch2", cfg_image_dim[23:16], 8'd32);
    check("t1_start", ch_start, 4'b0100);
    idle(1);
    check("t1_start_single", ch_start, 4'b0000);
    check("t1_busy2", ch_busy[2], 1'b1);
    idle(3);
    pulse(4'b0100);
    check("t1_busy2_done", ch_busy[2], 1'b0);
    check("t1_intr", accel_interrupt, 4'b0100);
    check("t1_irq_lag", irq, 1'b0);
    idle(1);
    check("t1_irq", irq, 1'b1);

    // 2: trigger to a running channel stalls until done, accepted next cycle
    issue(mk(R_SEL, 20'd1));
    issue(mk(R_TRIG, 20'd0));
    idle(1);
    step(1'b1, mk(R_TRIG, 20'd0), 4'b0000, a, r); check("t2_stall_a", r, 1'b0);
    step(1'b1, mk(R_TRIG, 20'd0), 4'b0000, a, r); check("t2_stall_b", r, 1'b0);
    step(1'b1, mk(R_TRIG, 20'd0), 4'b0010, a, r); check("t2_stall_done", r, 1'b0);
    step(1'b1, mk(R_TRIG, 20'd0), 4'b0000, a, r); check("t2_accept", r, 1'b1);
    check("t2_restart", ch_start, 4'b0010);

    // 3: shadow write to busy channel does not touch active until trigger
    issue(mk(R_SEL, 20'd0));
    issue(mk(R_LEN, 20'd5));
    issue(mk(R_TRIG, 20'd0));
    issue(mk(R_LEN, 20'd100));
    check("t3_len_held", cfg_filter_len[12:0], 13'd5);
    pulse(4'b0001);
    issue(mk(R_TRIG, 20'd0));
    check("t3_len_new", cfg_filter_len[12:0], 13'd100);

    // 4: out-of-range select ignored; done beats same-cycle clear
    idle(1);
    pulse(4'b0001);
    issue(mk(R_SEL, 20'd7));
    issue(mk(R_DIM, 20'h55));
    issue(mk(R_TRIG, 20'd0));
    check("t4_ptr_kept", cfg_image_dim[7:0], 8'h55);
    issue(mk(R_SEL, 20'd2));
    issue(mk(R_TRIG, 20'd0));
    idle(1);
    step(1'b1, mk(R_CLR, 20'b0100), 4'b0100, a, r);
    check("t4_set_wins", accel_interrupt[2], 1'b1);
    issue(mk(R_CLR, 20'b0010));
    check("t4_clear", accel_interrupt[1], 1'b0);

    // 5: trigger-all waits for every channel
    pulse(4'b0010);
    issue(mk(R_SEL, 20'd3));
    issue(mk(R_TRIG, 20'd0));
    idle(1);
    step(1'b1, mk(R_TALL, 20'd0), 4'b0000, a, r); check("t5_stall_a", r, 1'b0);
    step(1'b1, mk(R_TALL, 20'd0), 4'b0001, a, r); check("t5_stall_b", r, 1'b0);
    step(1'b1, mk(R_TALL, 20'd0), 4'b0000, a, r); check("t5_stall_c", r, 1'b0);
    step(1'b1, mk(R_TALL, 20'd0), 4'b1000, a, r); check("t5_stall_d", r, 1'b0);
    step(1'b1, mk(R_TALL, 20'd0), 4'b0000, a, r); check("t5_accept", r, 1'b1);
    check("t5_start_all", ch_start, 4'b1111);
    idle(1);
    check("t5_start_single", ch_start, 4'b0000);
    check("t5_busy_all", ch_busy, 4'b1111);

    // 6: reset mid-run, late done ignored, optional cycle counter
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    check("t6_busy_rst", ch_busy, 4'b0000);
    check("t6_intr_rst", accel_interrupt, 4'b0000);
    pulse(4'b1111);
    check("t6_late_done_busy", ch_busy, 4'b0000);
    check("t6_late_done_intr", accel_interrupt, 4'b0000);
    idle(1);
    check("t6_irq", irq, 1'b0);
    issue(mk(R_SEL, 20'd1));
    issue(mk(R_TRIG, 20'd0));
    idle(37);                              // START cycle plus 36 RUN cycles
    pulse(4'b0010);                        // 37th RUN cycle
`ifdef ACCEL_CMD_PERF_EN
    check("t6_cycles", ch_cycles[63:32], 32'd37);
    idle(3);
    check("t6_cycles_held", ch_cycles[63:32], 32'd37);
`endif

    // random phase
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      k = $urandom_range(0, 15);
      opc = OPC;
      imm = 20'($urandom);
      if (k < 9) rd = 5'(k);
      else if (k == 9) begin rd = R_SEL; imm = 20'($urandom_range(0, 7)); end
      else if (k == 10) rd = R_CLR;
      else if (k == 11 || k == 12) rd = R_TRIG;
      else if (k == 13) rd = R_TALL;
      else if (k == 14) rd = 5'($urandom_range(10, 28));
      else begin rd = 5'($urandom); opc = 7'($urandom_range(0, 127)) ^ OPC; if (opc == OPC) opc = 7'h33; end
      for (int c = 0; c < NUM_CH; c++) dn[c] = ($urandom_range(0, 4) == 0);
      step($urandom_range(0, 3) != 0, {imm, rd, opc}, dn, a, r);
    end
    rst = 1'b0;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
